// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants.
//   IFID_XLEN : datapath width used by the IF/ID bundle
//   NOP_INSTR : canonical RV32I NOP (addi x0, x0, 0)
//   ifid_t    : PC, PC+4 and instruction word passed from IF to ID
//   IFID_NOP  : bubble bundle presented by the IF/ID buffer when it is empty
package pipeline_pkg;

  localparam int unsigned IFID_XLEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [IFID_XLEN-1:0] pc;
    logic [IFID_XLEN-1:0] pc_plus4;
    logic [31:0]          instr;
  } ifid_t;

  localparam ifid_t IFID_NOP = '{pc: '0, pc_plus4: '0, instr: NOP_INSTR};

endpackage

// File: rtl/if_id_buffer.sv
// IF/ID pipeline buffer: 2-entry FIFO with valid/ready handshakes on both
// sides and a flush input that discards every buffered entry.
//
// Ports:
//   clk        : single clock, rising edge
//   reset      : synchronous active-high reset (priority over everything)
//   in_valid   : IF presents in_data
//   in_data    : ifid_t bundle from IF
//   in_ready   : buffer can accept in_data (registered state only)
//   out_valid  : out_data holds a live instruction
//   out_data   : oldest entry, or the NOP bundle when empty
//   out_ready  : ID consumes out_data this cycle
//   flush      : branch/jump redirect, empties the buffer at the next edge
//   stall_cnt  : (IFID_PERF_CNT_EN only) cycles with in_valid & ~in_ready
//   flush_cnt  : (IFID_PERF_CNT_EN only) flush cycles while non-empty
//
// Optional feature macro: IFID_PERF_CNT_EN
module if_id_buffer
  import pipeline_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  ifid_t       in_data,
  output logic        in_ready,
  output logic        out_valid,
  output ifid_t       out_data,
  input  logic        out_ready,
  input  logic        flush
`ifdef IFID_PERF_CNT_EN
 ,output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  // ifid_t field widths come from the package; the parameter must agree.
  if (XLEN != IFID_XLEN) begin : g_xlen_check
    $error("if_id_buffer: XLEN must match pipeline_pkg::IFID_XLEN");
  end

  logic [1:0] count;
  logic       wr_ptr;
  logic       rd_ptr;
  ifid_t      mem [2];
  logic       push;
  logic       pop;

  // in_ready depends only on count, so there is no out_ready -> in_ready path.
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = out_valid ? mem[rd_ptr] : IFID_NOP;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; a write during flush/reset lands in a slot that
  // the cleared count already marks as dead.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

`ifdef IFID_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (in_valid && !in_ready)      stall_cnt <= stall_cnt + 32'd1;
      if (flush && (count != 2'd0))   flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
module tb_if_id_buffer;
  import pipeline_pkg::*;

  logic  clk = 1'b0;
  logic  reset;
  logic  in_valid;
  ifid_t in_data;
  logic  in_ready;
  logic  out_valid;
  ifid_t out_data;
  logic  out_ready;
  logic  flush;
`ifdef IFID_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_id_buffer #(.XLEN(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .flush     (flush)
`ifdef IFID_PERF_CNT_EN
   ,.stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endfunction

  // Reference model: an ordered queue holding at most two bundles.
  logic [95:0] q[$];
  bit          model_ok = 0;
  int unsigned m_stall = 0;
  int unsigned m_flush = 0;
  int          sz;
  bit          mpush, mpop;
  logic [95:0] nop_bundle = {32'h0, 32'h0, 32'h00000013};

  always @(posedge clk) begin
    sz = q.size();
    if (reset) begin
      q.delete();
      model_ok = 1;
      m_stall  = 0;
      m_flush  = 0;
    end else begin
      if (in_valid && sz == 2) m_stall++;
      if (flush && sz != 0)    m_flush++;
      if (flush) begin
        q.delete();
      end else begin
        mpop  = (sz != 0) && out_ready;
        mpush = in_valid && (sz < 2);
        if (mpop)  void'(q.pop_front());
        if (mpush) q.push_back(in_data);
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("in_ready",  in_ready,  q.size() < 2);
      chk("out_valid", out_valid, q.size() != 0);
      chk("out_data",  out_data,  (q.size() != 0) ? q[0] : nop_bundle);
`ifdef IFID_PERF_CNT_EN
      chk("stall_cnt", stall_cnt, m_stall);
      chk("flush_cnt", flush_cnt, m_flush);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic ifid_t mk(logic [31:0] pc, logic [31:0] instr);
    ifid_t d;
    d.pc       = pc;
    d.pc_plus4 = pc + 32'd4;
    d.instr    = instr;
    return d;
  endfunction

  initial begin
    reset = 1; in_valid = 0; in_data = '0; out_ready = 0; flush = 0;
    cyc(); cyc();
    reset = 0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_nop", out_data.instr, 32'h00000013);

    // Single push, consumed immediately.
    in_valid = 1; in_data = mk(32'h100, 32'h00500093); out_ready = 1;
    cyc();
    in_valid = 0;
    chk("one_valid", out_valid, 1);
    chk("one_pc", out_data.pc, 32'h100);
    chk("one_pc4", out_data.pc_plus4, 32'h104);
    chk("one_instr", out_data.instr, 32'h00500093);
    cyc();
    chk("one_drained", out_valid, 0);

    // Fill with ID stalled, hold the third, then drain in order.
    out_ready = 0;
    in_valid = 1; in_data = mk(32'h0, 32'h13);
    cyc();
    chk("fill1_ready", in_ready, 1);
    in_data = mk(32'h4, 32'h13);
    cyc();
    chk("fill2_ready", in_ready, 0);
    in_data = mk(32'h8, 32'h13);
    cyc();
    cyc();
    chk("held_pc", out_data.pc, 32'h0);
    chk("held_ready", in_ready, 0);
    out_ready = 1;
    cyc();
    chk("drain_pc4", out_data.pc, 32'h4);
    cyc();
    in_valid = 0;
    chk("drain_pc8", out_data.pc, 32'h8);
    cyc();
    chk("drain_empty", out_valid, 0);
`ifdef IFID_PERF_CNT_EN
    chk("stall_is_3", stall_cnt, 3);
`endif

    // Steady state at one entry: push and pop every cycle across pointer wrap.
    in_valid = 1; in_data = mk(32'h40, 32'h13);
    cyc();
    for (int i = 0; i < 10; i++) begin
      in_data = mk(32'h44 + 32'(4 * i), 32'h13);
      cyc();
      chk("ss_valid", out_valid, 1);
      chk("ss_ready", in_ready, 1);
      chk("ss_pc", out_data.pc, 32'h44 + 32'(4 * i));
    end
    in_valid = 0;
    cyc();

    // Flush while full, with a concurrent push that must never appear.
    out_ready = 0;
    in_valid = 1; in_data = mk(32'h10, 32'h13); cyc();
    in_data = mk(32'h14, 32'h13); cyc();
    flush = 1; in_data = mk(32'h20, 32'h13);
    cyc();
    flush = 0; in_valid = 0; out_ready = 1;
    chk("flush_valid", out_valid, 0);
    chk("flush_nop", out_data.instr, 32'h00000013);
    chk("flush_ready", in_ready, 1);
`ifdef IFID_PERF_CNT_EN
    chk("flush_is_1", flush_cnt, 1);
`endif
    cyc();
    chk("flush_no20", out_valid, 0);

    // Reset while full.
    out_ready = 0; in_valid = 1;
    in_data = mk(32'h30, 32'h13); cyc();
    in_data = mk(32'h34, 32'h13); cyc();
    in_valid = 0; reset = 1;
    cyc();
    reset = 0;
    chk("rst2_valid", out_valid, 0);
    chk("rst2_ready", in_ready, 1);
`ifdef IFID_PERF_CNT_EN
    chk("rst2_stall", stall_cnt, 0);
`endif

    // Randomized traffic checked by the per-cycle compare process.
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      reset     = ($urandom_range(0, 199) == 0);
      in_data   = {$urandom, $urandom, $urandom};
      cyc();
    end
    reset = 0; in_valid = 0; flush = 0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_buffer.md
IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width of the PC, PCPlus4 and instr fields.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, meaning the IF stage presents a fetched instruction.
REQ-005 SHALL have port in_data, input, ifid_t, carrying PC, PCPlus4 and instr from the IF stage.
REQ-006 SHALL have port in_ready, output, 1, meaning the buffer can accept in_data this cycle.
REQ-007 SHALL have port out_valid, output, 1, meaning out_data holds a live instruction for ID.
REQ-008 SHALL have port out_data, output, ifid_t, the oldest buffered entry.
REQ-009 SHALL have port out_ready, input, 1, meaning ID consumes out_data this cycle.
REQ-010 SHALL have port flush, input, 1, the branch/jump redirect kill that discards all entries.

Function
REQ-011 SHALL implement a 2-entry FIFO of ifid_t with 1-bit wrapping read/write pointers and a 2-bit count (0..2).
REQ-012 SHALL assert push = in_valid & in_ready and pop = out_valid & out_ready.
REQ-013 SHALL drive in_ready = (count != 2) from registered state only, with no combinational path from out_ready.
REQ-014 SHALL drive out_valid = (count != 0), with out_data taken from the read-pointer entry.
REQ-015 SHALL drive out_data = {PC 0, PCPlus4 0, instr 32'h00000013 (NOP)} whenever out_valid = 0.
REQ-016 SHALL have 1-cycle latency: data pushed in cycle N appears on out_data in cycle N+1, with no same-cycle bypass.
REQ-017 SHALL handle simultaneous push and pop at count 1 by leaving count at 1, writing the new entry and advancing both pointers.
REQ-018 SHALL ignore pop when count = 0 and block push when count = 2, so no overflow or underflow can occur.
REQ-019 SHALL, when flush = 1, set count and both pointers to 0 at the next edge, discarding any same-cycle push and pop.
REQ-020 SHALL preserve entry order (FIFO) across pointer wrap-around.

Reset
REQ-021 SHALL, on reset, clear count and both pointers to 0, so in_ready = 1, out_valid = 0 and out_data = the REQ-015 NOP bundle.
REQ-022 SHALL give reset priority over flush, push and pop, including a reset asserted mid-stream.
REQ-023 SHALL not require the storage array to be reset.

Configuration
REQ-024 SHALL, when IFID_PERF_CNT_EN is defined, add 32-bit outputs stall_cnt (cycles with in_valid & ~in_ready) and flush_cnt (flush cycles with count != 0), both wrapping, both cleared by reset and unaffected by flush.
REQ-025 SHALL, when IFID_PERF_CNT_EN is undefined, have neither port nor counter logic.

Structure
REQ-026 SHALL take ifid_t and a NOP_INSTR constant (32'h00000013) from the shared pipeline_pkg; NOP_INSTR is added there.
REQ-027 SHALL be a single module with no sub-modules; storage and counters are inline.

Verification
REQ-028 SHALL cover reset then one push of {PC 0x100, PCPlus4 0x104, instr 0x00500093} with out_ready = 1: out_valid = 1 exactly one cycle later with those values, then out_valid = 0.
REQ-029 SHALL cover out_ready = 0 with pushes of PC 0x0, 0x4 and 0x8: in_ready drops after the second push, the third is held, and releasing out_ready drains 0x0, 0x4, 0x8 in order.
REQ-030 SHALL cover count = 1 with simultaneous push and pop over 10 cycles: count stays 1, the output PC sequence is strictly ordered, and the pointers wrap correctly.
REQ-031 SHALL cover flush at count = 2 with a concurrent push of PC 0x20: the next cycle has out_valid = 0, out_data.instr = 0x00000013 and in_ready = 1, and 0x20 is never emitted.
REQ-032 SHALL cover reset asserted at count = 2: the next cycle has count 0, out_valid = 0 and in_ready = 1.
REQ-033 SHALL cover, with IFID_PERF_CNT_EN defined, 3 stalled cycles and 1 non-empty flush: stall_cnt = 3 and flush_cnt = 1.
